sram_arbiter: RTL
=================

# sram_arbiter

Two-port round-robin arbiter and sequencer in front of the 64-bit, 23-bit-address `sram` block. Each requester issues single-beat read or write commands with a valid/ready handshake. The arbiter serializes the commands into registered SRAM controls, returns read data in order with fixed latency, and rejects row addresses beyond the physical depth.

## Interface
- `ROW_DEPTH`, 4096: number of implemented rows per bank. A request with `addr[22:5] >= ROW_DEPTH` is out of range.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `p0_req_valid` / `p1_req_valid` in 1: requester command valid.
- `p0_req_ready` / `p1_req_ready` out 1: command accepted this cycle.
- `p0_req_we` / `p1_req_we` in 1: 1 = write, 0 = read.
- `p0_req_addr` / `p1_req_addr` in 23: `[4:0]` is the bank; `[22:5]` is the row.
- `p0_req_wdata` / `p1_req_wdata` in 64: write data.
- `p0_rsp_valid` / `p1_rsp_valid` out 1: one-cycle read-response pulse.
- `p0_rsp_err` / `p1_rsp_err` out 1: out-of-range flag. Qualified by `rsp_valid`, or by `wr_err` for writes.
- `p0_wr_err` / `p1_wr_err` out 1: one-cycle pulse when an out-of-range write is dropped.
- `rsp_rdata` out 64: shared read data, qualified by either `rsp_valid`.
- `mem_address` out 23: to `sram.address`.
- `mem_wdata` out 64: to `sram.data_in`.
- `mem_we` out 1: to `sram.write_en`.
- `mem_rdata` in 64: from `sram.data_out`.

## Operation
- **Ready signals:**
  - `pX_req_ready = grant_X`, decided combinationally from the current valids and the priority pointer.
  - There is no backpressure from the SRAM, so at most one grant is issued per cycle.
  - A request is accepted at the clock edge where `valid && ready` is high.
- **Arbitration:**
  - A single valid requester is granted immediately.
  - When both requesters are valid, the port not granted most recently wins.
  - The pointer `last_grant` updates only on a grant. Its reset value is 1, so port 0 wins the first tie.
- **Stage A (edge of acceptance):**
  - Register `mem_address <= addr` and `mem_wdata <= wdata`.
  - Register `mem_we <= we && in_range`.
  - Register the tag {port, is_read, err = !in_range}.
  - With no acceptance, `mem_we <= 0`; `mem_address` and `mem_wdata` hold. The SRAM then performs a harmless read.
- **Stage B (next edge, SRAM executes):**
  - Read tag: set `rsp_valid` for the tagged port for one cycle and copy `err` to `pX_rsp_err`.
  - Write tag with err: pulse `pX_wr_err` and set `pX_rsp_err = 1` for that cycle.
  - In-range write: no response signal.
- **Read data:**
  - `rsp_rdata = mem_rdata` while the response is not in error, otherwise `64'h0`. It is combinational from the SRAM's registered output.
  - An out-of-range read is never sent to the SRAM as a distinct operation, and its data is forced to zero.
- **Ordering and throughput:**
  - Strict in-order completion; one command per cycle sustained.
  - Read-after-write to the same address in back-to-back cycles returns the new data, because the SRAM writes at the edge before the read executes.
- **Response path:** requesters must accept responses unconditionally; there is no response-ready.
- **Reset (`rst_n` = 0, asynchronous):**
  - Outputs: `mem_we = 0`, `mem_address = 0`, `mem_wdata = 0`.
  - All `rsp_valid`, `rsp_err` and `wr_err` = 0; `rsp_rdata` = 0.
  - Internal: tag pipeline cleared, `last_grant = 1`.
  - In-flight commands are discarded: no response is ever produced for them. This holds even if `rst_n` falls between stage A and stage B.
- **Requester assumption:** the SRAM's own `rst` is tied low, or driven separately; it is not controlled by this block.

## Timing
- Acceptance edge E0.
- `mem_*` are valid during cycle E0→E1; the SRAM samples them at E1.
- Read latency:
  - `rsp_valid` is high during cycle E1→E2, i.e. 2 edges after acceptance.
  - `rsp_rdata` is stable during that same cycle.
- Write is committed to the SRAM at E1. `wr_err` pulses during E1→E2.
- `req_ready` is combinational from `req_valid`, so there is no registered-ready bubble. Requesters must not make `req_valid` depend combinationally on `req_ready`.
- Deassertion of `rst_n` is synchronized externally. The first acceptance can occur at the first edge with `rst_n` = 1.

## Test plan
- **Reset values:** hold `rst_n` = 0 -> all outputs 0. Pull `rst_n` low mid-cycle after accepting a read -> no `rsp_valid` appears afterwards.
- **Single write then read:** p0 writes `addr = 23'h000123`, `data = 64'hDEADBEEF_0BADF00D` at E0. At E1 p0 reads the same address -> `p0_rsp_valid` during E2→E3 with that data, `rsp_err = 0`.
- **Contention:** both ports hold valid reads for 4 cycles -> grants go p0, p1, p0, p1. Responses arrive in the same order, 2 edges after each grant.
- **Out-of-range read:** p1 reads `addr[22:5] = 4096` -> `p1_rsp_valid = 1`, `p1_rsp_err = 1`, `rsp_rdata = 0`.
- **Out-of-range write:** p1 writes `addr[22:5] = 4096` -> `p1_wr_err` pulses 1 cycle, `mem_we` stays 0 throughout, and the SRAM contents are unchanged.
- **Back-to-back streaming:** p0 issues 8 consecutive writes, then 8 reads to banks 0–7 with p1 idle -> `p0_req_ready` is high every cycle, and 8 consecutive `rsp_valid` pulses return matching data.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Requester-side command/response bundle for one sram_arbiter port.
// The requester drives the command; the arbiter drives ready and the response pulses.
interface sram_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [22:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic        wr_err;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_err,
    input  wr_err
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_err,
    output wr_err
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter feeding registered controls to a single-port 64-bit SRAM.
// Commands complete in order; read responses appear two edges after acceptance.
module sram_arbiter #(
  parameter int unsigned ROW_DEPTH = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  sram_arbiter_if.slave    p0,
  sram_arbiter_if.slave    p1,
  output logic [63:0]      rsp_rdata,
  output logic [22:0]      mem_address,
  output logic [63:0]      mem_wdata,
  output logic             mem_we,
  input  logic [63:0]      mem_rdata
);

  localparam logic [18:0] RowLimit = 19'(ROW_DEPTH);

  typedef struct packed {
    logic valid;
    logic port;
    logic is_read;
    logic err;
  } tag_t;

  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        sel;
  logic [22:0] sel_addr;
  logic [63:0] sel_wdata;
  logic        sel_we;
  logic        sel_in_range;

  logic        last_grant_q, last_grant_d;
  logic [22:0] mem_address_q, mem_address_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  tag_t        tag_a_q, tag_a_d;
  tag_t        tag_b_q;

  logic        hit0;
  logic        hit1;

  // last_grant_q holds the port served most recently; on a tie the other one wins.
  always_comb begin
    grant0 = p0.req_valid && (!p1.req_valid || last_grant_q);
    grant1 = p1.req_valid && (!p0.req_valid || !last_grant_q);
  end

  assign p0.req_ready = grant0;
  assign p1.req_ready = grant1;

  always_comb begin
    accept        = grant0 || grant1;
    sel           = grant1;
    sel_addr      = sel ? p1.req_addr  : p0.req_addr;
    sel_wdata     = sel ? p1.req_wdata : p0.req_wdata;
    sel_we        = sel ? p1.req_we    : p0.req_we;
    sel_in_range  = {1'b0, sel_addr[22:5]} < RowLimit;

    last_grant_d  = last_grant_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_d      = 1'b0;
    tag_a_d       = '0;

    if (accept) begin
      last_grant_d    = sel;
      mem_address_d   = sel_addr;
      mem_wdata_d     = sel_wdata;
      // Out-of-range writes are demoted to a harmless read of the presented address.
      mem_we_d        = sel_we && sel_in_range;
      tag_a_d.valid   = 1'b1;
      tag_a_d.port    = sel;
      tag_a_d.is_read = !sel_we;
      tag_a_d.err     = !sel_in_range;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q  <= 1'b1;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
      tag_a_q       <= '0;
      tag_b_q       <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
      tag_a_q       <= tag_a_d;
      tag_b_q       <= tag_a_q;
    end
  end

  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;

  // Stage B lines up with the SRAM's registered read data.
  assign hit0 = tag_b_q.valid && !tag_b_q.port;
  assign hit1 = tag_b_q.valid &&  tag_b_q.port;

  assign p0.rsp_valid = hit0 && tag_b_q.is_read;
  assign p0.rsp_err   = hit0 && tag_b_q.err;
  assign p0.wr_err    = hit0 && !tag_b_q.is_read && tag_b_q.err;
  assign p1.rsp_valid = hit1 && tag_b_q.is_read;
  assign p1.rsp_err   = hit1 && tag_b_q.err;
  assign p1.wr_err    = hit1 && !tag_b_q.is_read && tag_b_q.err;

  assign rsp_rdata = (tag_b_q.valid && tag_b_q.is_read && !tag_b_q.err) ? mem_rdata : 64'h0;

  grant_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) !(grant0 && grant1));
  we_in_range_a:  assert property (@(posedge clk) disable iff (!rst_n)
                                   mem_we |-> ({1'b0, mem_address[22:5]} < RowLimit));

endmodule
